// File: rtl/sign_mag_pkg.sv
// sign_mag_pkg: shared op encodings for the sign-magnitude ALU
package sign_mag_pkg;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ACC = 2'b10;
  localparam logic [1:0] OP_LD  = 2'b11;
endpackage

// File: rtl/sign_mag_core.sv
// sign_mag_core: combinational sign-magnitude add with saturate/wrap and canonical zero
// Ports: x, y - sign-magnitude operands; res - canonical result; ovf - magnitude carry out
module sign_mag_core #(
  parameter int N   = 8,
  parameter bit SAT = 1'b1
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  output logic [N-1:0] res,
  output logic         ovf
);
  logic [N-2:0] mx, my, mag;
  logic [N-1:0] add;
  logic         sx, sy, same, x_ge, sgn;
  assign mx   = x[N-2:0];
  assign my   = y[N-2:0];
  // -0 operands behave as +0
  assign sx   = x[N-1] && |mx;
  assign sy   = y[N-1] && |my;
  assign same = sx == sy;
  assign x_ge = mx >= my;
  assign add  = {1'b0, mx} + {1'b0, my};
  assign ovf  = same && add[N-1];
  assign mag  = same ? ((ovf && SAT) ? '1 : add[N-2:0]) : (x_ge ? mx - my : my - mx);
  assign sgn  = same ? sx : (x_ge ? sx : sy);
  // zero magnitude (including wrapped results) is always +0
  assign res  = {sgn && |mag, mag};
endmodule

// File: rtl/sign_mag_alu_pipe.sv
// sign_mag_alu_pipe: two-stage valid/ready sign-magnitude add/sub/accumulate unit
// Ports: clk, rst_n (async active-low); in_valid/in_ready with a, b, op;
//        out_valid/out_ready with sum, ovf
module sign_mag_alu_pipe
  import sign_mag_pkg::*;
#(
  parameter int N   = 8,
  parameter bit SAT = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [1:0]   op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         ovf
);
  logic         s1_valid, s1_adv, s2_adv, core_ovf;
  logic [N-1:0] s1_a, s1_b, acc, x, y, res;
  logic [1:0]   s1_op;
  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = s1_valid && s2_adv;
  assign in_ready = rst_n && (!s1_valid || s2_adv);
  assign x = s1_op == OP_ACC ? acc : s1_a;
  // load adds a to +0, which yields a canonicalised with no overflow
  assign y = s1_op == OP_SUB ? {~s1_b[N-1], s1_b[N-2:0]} :
             s1_op == OP_ADD ? s1_b :
             s1_op == OP_ACC ? s1_a : '0;
  sign_mag_core #(.N(N), .SAT(SAT)) u_core (
    .x   (x),
    .y   (y),
    .res (res),
    .ovf (core_ovf)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_op     <= OP_ADD;
      out_valid <= 1'b0;
      sum       <= '0;
      ovf       <= 1'b0;
      acc       <= '0;
    end else begin
      if (in_valid && in_ready) begin
        s1_valid <= 1'b1;
        s1_a     <= a;
        s1_b     <= b;
        s1_op    <= op;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end
      if (s1_adv) begin
        out_valid <= 1'b1;
        sum       <= res;
        ovf       <= core_ovf;
        if (s1_op[1]) acc <= res;
      end else if (s2_adv) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_sign_mag_alu_pipe.sv
// tb_sign_mag_alu_pipe: directed scoreboard bench for saturating and wrapping instances
module tb_sign_mag_alu_pipe;
  import sign_mag_pkg::*;
  typedef struct {
    logic [7:0] s1;
    logic       o1;
    logic [7:0] s0;
    logic       o0;
  } exp_t;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic [1:0] op = OP_ADD;
  logic       in_ready1, in_ready0, out_valid1, out_valid0, ovf1, ovf0;
  logic [7:0] sum1, sum0;
  exp_t       q[$];
  int         checks = 0;
  int         errors = 0;
  always #5 clk = ~clk;
  sign_mag_alu_pipe #(.N(8), .SAT(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .a(a), .b(b), .op(op), .out_valid(out_valid1), .out_ready(out_ready),
    .sum(sum1), .ovf(ovf1)
  );
  sign_mag_alu_pipe #(.N(8), .SAT(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .a(a), .b(b), .op(op), .out_valid(out_valid0), .out_ready(out_ready),
    .sum(sum0), .ovf(ovf0)
  );
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst_n && out_valid1 && out_ready) begin
      chk("out_has_expected", 8'(q.size() != 0), 8'd1);
      chk("valid_sat0", 8'(out_valid0), 8'd1);
      if (q.size() != 0) begin
        exp_t e;
        e = q.pop_front();
        chk("sum_sat1", sum1, e.s1);
        chk("ovf_sat1", 8'(ovf1), 8'(e.o1));
        chk("sum_sat0", sum0, e.s0);
        chk("ovf_sat0", 8'(ovf0), 8'(e.o0));
      end
    end
  end
  task automatic send(input logic [1:0] o, input logic [7:0] av, input logic [7:0] bv,
                      input logic [7:0] e1, input logic eo1, input logic [7:0] e0, input logic eo0);
    int n = 0;
    op = o;
    a = av;
    b = bv;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready1 && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("accept_timeout", 8'(n < 50), 8'd1);
    q.push_back('{e1, eo1, e0, eo0});
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 50) begin
      n++;
      @(posedge clk);
    end
    #1 chk("drain", 8'(q.size()), 8'd0);
  endtask
  initial begin
    #12;
    chk("rst_out_valid", 8'(out_valid1), 8'd0);
    chk("rst_in_ready", 8'(in_ready1), 8'd0);
    chk("rst_sum", sum1, 8'h00);
    chk("rst_ovf", 8'(ovf1), 8'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    send(OP_ADD, 8'h05, 8'h83, 8'h02, 0, 8'h02, 0);
    chk("lat_not_yet", 8'(out_valid1), 8'd0);
    @(posedge clk);
    #1 chk("lat_two_edges", 8'(out_valid1), 8'd1);
    chk("lat_sum", sum1, 8'h02);
    send(OP_SUB, 8'h05, 8'h03, 8'h02, 0, 8'h02, 0);
    send(OP_ADD, 8'h03, 8'h83, 8'h00, 0, 8'h00, 0);
    send(OP_ADD, 8'h80, 8'h80, 8'h00, 0, 8'h00, 0);
    send(OP_LD,  8'h80, 8'h55, 8'h00, 0, 8'h00, 0);
    send(OP_ADD, 8'h7F, 8'h01, 8'h7F, 1, 8'h00, 1);
    send(OP_ADD, 8'hFF, 8'h81, 8'hFF, 1, 8'h00, 1);
    send(OP_ADD, 8'h03, 8'h85, 8'h82, 0, 8'h82, 0);
    send(OP_SUB, 8'h83, 8'h04, 8'h87, 0, 8'h87, 0);
    send(OP_SUB, 8'h05, 8'h80, 8'h05, 0, 8'h05, 0);
    send(OP_LD,  8'h0A, 8'h00, 8'h0A, 0, 8'h0A, 0);
    send(OP_ACC, 8'h85, 8'h00, 8'h05, 0, 8'h05, 0);
    send(OP_ADD, 8'h01, 8'h01, 8'h02, 0, 8'h02, 0);
    send(OP_ACC, 8'h85, 8'h00, 8'h00, 0, 8'h00, 0);
    send(OP_ACC, 8'h83, 8'h00, 8'h83, 0, 8'h83, 0);
    drain();
    out_ready = 1'b0;
    send(OP_ADD, 8'h01, 8'h01, 8'h02, 0, 8'h02, 0);
    send(OP_ADD, 8'h02, 8'h01, 8'h03, 0, 8'h03, 0);
    op = OP_ADD;
    a = 8'h03;
    b = 8'h01;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_in_ready_low", 8'(in_ready1), 8'd0);
      chk("bp_out_valid", 8'(out_valid1), 8'd1);
      chk("bp_sum_stable", sum1, 8'h02);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(OP_ADD, 8'h03, 8'h01, 8'h04, 0, 8'h04, 0);
    send(OP_ADD, 8'h04, 8'h01, 8'h05, 0, 8'h05, 0);
    send(OP_ADD, 8'h05, 8'h01, 8'h06, 0, 8'h06, 0);
    send(OP_ADD, 8'h06, 8'h01, 8'h07, 0, 8'h07, 0);
    drain();
    out_ready = 1'b0;
    send(OP_LD, 8'h10, 8'h00, 8'h10, 0, 8'h10, 0);
    send(OP_LD, 8'h20, 8'h00, 8'h20, 0, 8'h20, 0);
    #2 rst_n = 1'b0;
    #1 chk("midrst_out_valid", 8'(out_valid1), 8'd0);
    chk("midrst_in_ready", 8'(in_ready1), 8'd0);
    chk("midrst_sum", sum1, 8'h00);
    q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    send(OP_ACC, 8'h03, 8'h00, 8'h03, 0, 8'h03, 0);
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sign_mag_alu_pipe.md
# sign_mag_alu_pipe

Parametrised, pipelined sign-magnitude arithmetic unit: add, subtract, load-accumulator and accumulate on N-bit sign-magnitude operands (MSB = sign, N-1 magnitude bits). Results are canonical (never -0), with selectable saturate/wrap overflow handling and an overflow flag. It sits in the datapath wherever sign-magnitude sensor or DSP samples are combined. Valid/ready streams on both sides allow chaining and back-pressure.

## Interface

- N, 8, total word width including sign bit; N >= 2
- SAT, 1, 1 = saturate magnitude to all-ones on overflow; 0 = wrap (drop carry)

- clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset (one clock domain)
- in_valid  in  1  operand/op presented
- in_ready  out  1  block accepts; transfer when in_valid && in_ready
- a  in  N  operand A, sign-magnitude
- b  in  N  operand B, sign-magnitude (ignored for ops 10, 11)
- op  in  2  00 a+b, 01 a-b, 10 acc+a, 11 load acc with a
- out_valid  out  1  result held on sum/ovf
- out_ready  in  1  consumer accepts; transfer when out_valid && out_ready
- sum  out  N  result, sign-magnitude, canonical
- ovf  out  1  magnitude overflow occurred for this result

## Operation

- Two registers: S1 (captured a, b, op) and S2 (sum, ovf). Combinational compute between S1 and S2.
- Sub: B sign inverted before add. Any ±0 operand is treated as +0.
- Core rule, on operands X, Y: equal signs -> mag = |X|+|Y| (N-bit with carry), sign = common sign. Different signs -> mag = larger - smaller, sign = sign of larger magnitude. Equal magnitudes -> +0.
- Overflow: carry out of the N-1-bit magnitude sets ovf. SAT=1 -> mag = 2^(N-1)-1, sign kept. SAT=0 -> mag = low N-1 bits.
- Canonicalisation: zero magnitude always forces sign 0, including wrapped results.
- Ops 00/01: X = a, Y = b (or negated b).
- Op 10: X = acc, Y = a.
- Op 11: result = a canonicalised, ovf = 0.
- Internal acc register (N bits) is loaded with the result of ops 10/11 on the edge where that op moves S1->S2. Ops 00/01 leave acc untouched.
- Ordering is strict: results emerge in acceptance order and acc is always current for the op in S1.

## Timing

- Reset (async assert, sync-released use): S1/S2 valid = 0, sum = 0, ovf = 0, acc = 0. out_valid = 0, and in_ready = 0 while reset is low.
- s2_adv = !out_valid || out_ready. s1_adv = s1_valid && s2_adv. in_ready = !s1_valid || s2_adv (combinational from out_ready; accepted path).
- Latency: operand accepted on edge k -> out_valid with result after edge k+1 (visible in the cycle after k+1), i.e. 2 edges. Throughput 1 op/cycle with out_ready held high.
- Back-pressure: out_ready low holds sum/ovf/out_valid stable. At most 2 ops are buffered, then in_ready drops. No loss, no duplication.
- Simultaneous accept on input and output in the same cycle is legal and keeps full throughput.
- Reset mid-operation: all in-flight ops are discarded and acc is cleared. There is no partial output.

## Structure

- Shared package/include sign_mag_pkg: op encodings (OP_ADD, OP_SUB, OP_ACC, OP_LD) as localparams.
- One sub-module: sign_mag_core, combinational, parameters N and SAT. Inputs are X, Y; outputs are canonical result and ovf. It contains the sort/add/sub/saturate/normalise logic.
- The top holds S1, S2, acc and handshake logic.

## Test plan

- N=8, SAT=1: op00 a=0x05, b=0x83 -> sum 0x02, ovf 0, out_valid exactly 2 edges after accept. op01 a=0x05, b=0x03 -> 0x02.
- Zero canonicalisation: op00 0x03+0x83 -> 0x00; 0x80+0x80 -> 0x00; op11 a=0x80 -> 0x00.
- Overflow: 0x7F+0x01 -> SAT=1: 0x7F ovf 1; SAT=0: 0x00 ovf 1. 0xFF+0x81 -> SAT=1: 0xFF ovf 1.
- Accumulate back-to-back: op11 0x0A, op10 0x85, op10 0x85, op10 0x83 -> 0x0A, 0x05, 0x00, 0x83. An interleaved op00 does not disturb acc.
- Back-pressure: stream 6 ops, out_ready low for 5 cycles -> in_ready low after 2 accepted. On release, all 6 results arrive in order and sum stays stable while stalled.
- Reset with S1 and S2 full -> out_valid 0 immediately, acc 0. Then op10 a=0x03 -> 0x03.
